// File: rtl/led_mmio_if.sv
// Core data-memory port as seen by the LED peripheral: single-cycle load/store strobes,
// registered load data qualified by a one-cycle rvalid pulse.
interface led_mmio_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (output addr, wdata, be, we, re, input  rdata, rvalid);
    modport slave  (input  addr, wdata, be, we, re, output rdata, rvalid);
endinterface

// File: rtl/led_mmio.sv
// LED peripheral: DATA/MODE/DIV/STATUS registers in a 16-byte window, blink engine, registered LEDR drive.
// Latency: load data 1 cycle after bus re; a store reaches ledr 1 cycle after the register updates.
// Backpressure: none; a load and/or store is accepted every cycle.
module led_mmio #(
    parameter logic [31:0] BASE_ADDR = 32'hFF20_0000,
    parameter int          LED_WIDTH = 10,
    parameter logic [31:0] DIV_RESET = 32'd25_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    led_mmio_if.slave            bus,
    output logic [LED_WIDTH-1:0] ledr
);
    logic                 hit;
    logic [1:0]           sel;
    logic                 wr_hit;
    logic                 rd_hit;
    logic [LED_WIDTH-1:0] data_q;
    logic                 blink_en;
    logic                 invert;
    logic [31:0]          div_q;
    logic [31:0]          cnt;
    logic                 phase;
    logic                 wrap;
    logic [31:0]          rd_word;
    logic [31:0]          wr_word;
    logic                 unused_addr_lsbs;

    assign hit              = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign sel              = bus.addr[3:2];
    assign wr_hit           = bus.we & hit;
    assign rd_hit           = bus.re & hit;
    assign unused_addr_lsbs = ^bus.addr[1:0];
    assign wrap             = (div_q == 32'd0) || (cnt >= div_q - 32'd1);

    // Selected register as currently held; also the base for byte-lane merging on stores.
    always_comb begin
        rd_word = 32'd0;
        case (sel)
            2'd0: rd_word[LED_WIDTH-1:0] = data_q;
            2'd1: rd_word[1:0]           = {invert, blink_en};
            2'd2: rd_word                = div_q;
            default: rd_word[1:0]        = {blink_en & (cnt == 32'd0), phase};
        endcase
    end

    always_comb begin
        wr_word = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (bus.be[i]) wr_word[8*i +: 8] = bus.wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q   <= '0;
            blink_en <= 1'b0;
            invert   <= 1'b0;
            div_q    <= DIV_RESET;
        end else if (wr_hit) begin
            case (sel)
                2'd0:    data_q <= wr_word[LED_WIDTH-1:0];
                2'd1:    {invert, blink_en} <= wr_word[1:0];
                2'd2:    div_q <= wr_word;
                default: ;
            endcase
        end
    end

    // A DIV store restarts the count so the new half-period starts cleanly; phase is kept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= 32'd0;
            phase <= 1'b0;
        end else begin
            if (!blink_en) begin
                cnt   <= 32'd0;
                phase <= 1'b0;
            end else if (wrap) begin
                cnt   <= 32'd0;
                phase <= ~phase;
            end else begin
                cnt   <= cnt + 32'd1;
            end
            if (wr_hit && sel == 2'd2) cnt <= 32'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.rdata  <= 32'd0;
            bus.rvalid <= 1'b0;
        end else begin
            bus.rvalid <= rd_hit;
            if (rd_hit) bus.rdata <= rd_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ledr <= '0;
        end else begin
            ledr <= ((blink_en & phase) ? '0 : data_q) ^ {LED_WIDTH{invert}};
        end
    end
endmodule

// File: tb/tb_led_mmio.sv
// Bench for led_mmio: directed scenarios plus random bus traffic against a countdown-based reference model.
module tb_led_mmio;
    localparam logic [31:0] BASE = 32'hFF20_0000;
    localparam int          LW   = 10;
    localparam logic [31:0] MASK = 32'h0000_03FF;
    localparam logic [31:0] DIVR = 32'd25_000_000;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic [LW-1:0] ledr;

    led_mmio_if bus_if ();

    led_mmio #(.BASE_ADDR(BASE), .LED_WIDTH(LW), .DIV_RESET(DIVR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if),
        .ledr  (ledr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: phase is tracked with a countdown of cycles left until the next toggle.
    logic [31:0] m_data, m_div, m_left, m_ledr, m_rdata;
    logic [1:0]  m_mode;
    logic        m_phase, m_rvalid;

    function automatic logic [31:0] period(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_data = 0; m_mode = 0; m_div = DIVR; m_left = period(DIVR);
        m_phase = 0; m_ledr = 0; m_rdata = 0; m_rvalid = 0;
    endtask

    task automatic model_step(input logic re, input logic we, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] be);
        logic        hit;
        int          s;
        logic [31:0] regs [4];
        logic [31:0] v;
        hit = (a >> 4) == (BASE >> 4);
        s = int'(a[3:2]);
        regs[0] = m_data;
        regs[1] = {30'd0, m_mode};
        regs[2] = m_div;
        regs[3] = {30'd0, (m_mode[0] && m_left == period(m_div)), m_phase};
        m_rvalid = re && hit;
        if (re && hit) m_rdata = regs[s];
        m_ledr = ((m_mode[0] && m_phase) ? 32'd0 : m_data) ^ (m_mode[1] ? MASK : 32'd0);
        if (!m_mode[0]) begin
            m_phase = 0;
            m_left  = period(m_div);
        end else if (m_left == 32'd1) begin
            m_phase = !m_phase;
            m_left  = period(m_div);
        end else begin
            m_left = m_left - 1;
        end
        if (we && hit && s != 3) begin
            v = regs[s];
            for (int i = 0; i < 4; i++) if (be[i]) v[8*i +: 8] = wd[8*i +: 8];
            case (s)
                0: m_data = v & MASK;
                1: m_mode = v[1:0];
                default: begin m_div = v; m_left = period(v); end
            endcase
        end
    endtask

    task automatic cycle(input logic re, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        bus_if.re = re; bus_if.we = we; bus_if.addr = a; bus_if.wdata = wd; bus_if.be = be;
        @(posedge clk);
        if (!reset) model_reset();
        else model_step(re, we, a, wd, be);
        #1;
        chk("ledr", 32'(ledr), m_ledr);
        chk("rvalid", 32'(bus_if.rvalid), 32'(m_rvalid));
        chk("rdata", bus_if.rdata, m_rdata);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, BASE, 32'd0, 4'h0);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] be);
        cycle(1'b0, 1'b1, BASE + off, d, be);
    endtask

    task automatic rd(input logic [31:0] off);
        cycle(1'b1, 1'b0, BASE + off, 32'd0, 4'h0);
    endtask

    task automatic rand_op();
        logic [31:0] a, d;
        logic [3:0]  be;
        int          k;
        k  = int'($urandom_range(0, 9));
        a  = BASE + {28'd0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
        if ($urandom_range(0, 9) == 0) a = $urandom_range(0, 1) ? BASE + 32'd16 * $urandom_range(1, 8) : $urandom;
        be = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
        d  = $urandom;
        if (a[3:2] == 2'd2) d = $urandom_range(0, 6);
        cycle(k >= 3 && (k <= 5 || k == 9), k >= 6, a, d, be);
    endtask

    task automatic async_reset_pulse();
        #2 reset = 1'b0;
        #1;
        chk("arst_ledr", 32'(ledr), 32'd0);
        chk("arst_rvalid", 32'(bus_if.rvalid), 32'd0);
        chk("arst_rdata", bus_if.rdata, 32'd0);
        model_reset();
        for (int i = 0; i < 3; i++) rand_op();
        reset = 1'b1;
    endtask

    initial begin
        bus_if.re = 0; bus_if.we = 0; bus_if.addr = 0; bus_if.wdata = 0; bus_if.be = 0;
        model_reset();

        for (int i = 0; i < 10; i++) rand_op();
        chk("reset_ledr", 32'(ledr), 32'd0);
        chk("reset_rvalid", 32'(bus_if.rvalid), 32'd0);
        reset = 1'b1;
        rd(32'd8);
        chk("div_reset", bus_if.rdata, 32'd25_000_000);

        wr(32'd0, 32'h0000_03A5, 4'hF);
        idle();
        chk("full_store_ledr", 32'(ledr), 32'h3A5);
        rd(32'd0);
        chk("full_store_rvalid", 32'(bus_if.rvalid), 32'd1);
        chk("full_store_rdata", bus_if.rdata, 32'h0000_03A5);

        wr(32'd0, 32'h0000_00A5, 4'hF);
        wr(32'd0, 32'hFFFF_FF00, 4'b0010);
        idle();
        chk("be_store_ledr", 32'(ledr), 32'h3A5);
        rd(32'd0);
        chk("be_store_rdata", bus_if.rdata, 32'h3A5);

        wr(32'd8, 32'd4, 4'hF);
        wr(32'd0, 32'h3FF, 4'hF);
        wr(32'd4, 32'd1, 4'hF);
        for (int i = 0; i < 20; i++) idle();
        wr(32'd4, 32'd0, 4'hF);
        idle(); idle();
        chk("blink_off_ledr", 32'(ledr), 32'h3FF);

        wr(32'd8, 32'd0, 4'hF);
        wr(32'd0, 32'd0, 4'hF);
        wr(32'd4, 32'd3, 4'hF);
        for (int i = 0; i < 6; i++) idle();
        rd(32'd12);
        idle();
        rd(32'd12);
        wr(32'd4, 32'd0, 4'hF);

        wr(32'd0, 32'h001, 4'hF);
        wr(32'd16, 32'h155, 4'hF);
        rd(32'd16);
        chk("miss_rvalid", 32'(bus_if.rvalid), 32'd0);
        cycle(1'b1, 1'b1, BASE, 32'h002, 4'hF);
        chk("collide_old", bus_if.rdata, 32'd1);
        rd(32'd0);
        chk("collide_new", bus_if.rdata, 32'd2);

        for (int i = 0; i < 200; i++) rand_op();
        wr(32'd8, 32'd3, 4'hF);
        wr(32'd4, 32'd1, 4'hF);
        for (int i = 0; i < 5; i++) idle();
        async_reset_pulse();
        rd(32'd8);
        for (int i = 0; i < 300; i++) rand_op();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
